// File: rtl/cclut_clct_packer_if.sv
// cclut_clct_packer_if: stream bundle for the CLCT packer.
//   Carries the stage-1 lookup inputs (strobe plus per-CLCT hit/pid/key/offs/bend)
//   and the FWFT output handshake (out_valid/out_ready/out_data).
//   master: producer of lookup results and consumer of packed words (e.g. testbench).
//   slave : the packer itself.
interface cclut_clct_packer_if #(
    parameter int unsigned MXKEYBX = 8,
    parameter int unsigned MXOFFSB = 4,
    parameter int unsigned MXBNDB  = 5,
    parameter int unsigned MXPIDB  = 4,
    parameter int unsigned MXHITB  = 3
);
    localparam int unsigned WORDW = MXHITB + MXPIDB + MXKEYBX + MXOFFSB + MXBNDB;

    logic               in_strobe;
    logic [MXHITB-1:0]  hit0,      hit1;
    logic [MXPIDB-1:0]  pid0,      pid1;
    logic [MXKEYBX-1:0] best_key0, best_key1;
    logic [MXOFFSB-1:0] offs0,     offs1;
    logic [MXBNDB-1:0]  bend0,     bend1;

    logic               out_valid;
    logic               out_ready;
    logic [WORDW-1:0]   out_data;

    modport master (
        output in_strobe, hit0, hit1, pid0, pid1, best_key0, best_key1,
        output offs0, offs1, bend0, bend1,
        output out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_strobe, hit0, hit1, pid0, pid1, best_key0, best_key1,
        input  offs0, offs1, bend0, bend1,
        input  out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/cclut_clct_packer.sv
// cclut_clct_packer: registers two per-BX CCLUT lookup results, applies the hit
// threshold and pattern-ID range check, cancels ghosts, packs survivors into
// {hit, pid, key, offs, bend} words and buffers them in a FWFT FIFO.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   bus (slave)    lookup inputs and out_valid/out_ready/out_data stream
//   hit_thresh     minimum layer-hit count to accept a CLCT
//   ghost_sep      ghost window in 1/2-strips, 0 disables cancellation
//   word_count     words currently held in the FIFO
//   drop_count     saturating count of words lost to a full FIFO
//   overflow       sticky flag, set on any dropped word
module cclut_clct_packer #(
    parameter int unsigned MXKEYBX    = 8,
    parameter int unsigned MXOFFSB    = 4,
    parameter int unsigned MXBNDB     = 5,
    parameter int unsigned MXPIDB     = 4,
    parameter int unsigned MXHITB     = 3,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MXCNTB     = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    cclut_clct_packer_if.slave          bus,
    input  logic [MXHITB-1:0]           hit_thresh,
    input  logic [3:0]                  ghost_sep,
    output logic [$clog2(FIFO_DEPTH):0] word_count,
    output logic [MXCNTB-1:0]           drop_count,
    output logic                        overflow
);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned WordW  = MXHITB + MXPIDB + MXKEYBX + MXOFFSB + MXBNDB;
    localparam int unsigned PidMax = 4;

    // ------------------------------------------------------------------
    // Stage 1: capture lookup results. Index 0 = CLCT0, index 1 = CLCT1.
    // ------------------------------------------------------------------
    logic                          s1_valid_d, s1_valid_q;
    logic [1:0][MXHITB-1:0]        s1_hit_d,   s1_hit_q;
    logic [1:0][MXPIDB-1:0]        s1_pid_d,   s1_pid_q;
    logic [1:0][MXKEYBX-1:0]       s1_key_d,   s1_key_q;
    logic [1:0][MXOFFSB-1:0]       s1_offs_d,  s1_offs_q;
    logic [1:0][MXBNDB-1:0]        s1_bend_d,  s1_bend_q;

    always_comb begin
        s1_valid_d = bus.in_strobe;
        s1_hit_d   = s1_hit_q;
        s1_pid_d   = s1_pid_q;
        s1_key_d   = s1_key_q;
        s1_offs_d  = s1_offs_q;
        s1_bend_d  = s1_bend_q;
        if (bus.in_strobe) begin
            s1_hit_d  = {bus.hit1,      bus.hit0};
            s1_pid_d  = {bus.pid1,      bus.pid0};
            s1_key_d  = {bus.best_key1, bus.best_key0};
            s1_offs_d = {bus.offs1,     bus.offs0};
            s1_bend_d = {bus.bend1,     bus.bend0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_pid_q   <= '0;
            s1_key_q   <= '0;
            s1_offs_q  <= '0;
            s1_bend_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_pid_q   <= s1_pid_d;
            s1_key_q   <= s1_key_d;
            s1_offs_q  <= s1_offs_d;
            s1_bend_q  <= s1_bend_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: qualify, ghost-cancel and pack.
    // ------------------------------------------------------------------
    logic [1:0]              acc;
    logic [1:0][WordW-1:0]   word;
    logic [MXKEYBX-1:0]      key_diff;
    logic                    ghost;
    logic                    keep1;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc[i]  = s1_valid_q && (s1_hit_q[i] >= hit_thresh) &&
                      (s1_pid_q[i] <= MXPIDB'(PidMax));
            word[i] = {s1_hit_q[i], s1_pid_q[i], s1_key_q[i], s1_offs_q[i], s1_bend_q[i]};
        end
        key_diff = (s1_key_q[0] >= s1_key_q[1]) ? (s1_key_q[0] - s1_key_q[1])
                                                : (s1_key_q[1] - s1_key_q[0]);
        // CLCT1 is the one sacrificed when the two keys sit inside the window.
        ghost = acc[0] && acc[1] && (ghost_sep != 4'd0) && (key_diff < MXKEYBX'(ghost_sep));
        keep1 = acc[1] && !ghost;
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [WordW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_d, wr_ptr_q;
    logic [AW-1:0]     rd_ptr_d, rd_ptr_q;
    logic [AW-1:0]     wr_ptr_p1;
    logic [CW-1:0]     count_d,  count_q;
    logic [MXCNTB-1:0] drop_d,   drop_q;
    logic              overflow_d, overflow_q;

    logic [1:0]        n_req;
    logic [1:0]        n_wr;
    logic [1:0]        n_drop;
    logic [CW-1:0]     free;
    logic              pop;
    logic [WordW-1:0]  wdata0;
    logic [WordW-1:0]  wdata1;
    logic [MXCNTB:0]   drop_sum;

    always_comb begin
        n_req  = {1'b0, acc[0]} + {1'b0, keep1};
        // Room is judged on the pre-edge count: a same-cycle pop frees nothing.
        free   = CW'(FIFO_DEPTH) - count_q;
        if (free >= CW'(n_req)) begin
            n_wr = n_req;
        end else begin
            // free < n_req <= 2, so free fits in two bits here.
            n_wr = free[1:0];
        end
        n_drop = n_req - n_wr;

        // Slot order is CLCT0 then CLCT1; if CLCT0 is rejected CLCT1 takes slot 0.
        wdata0 = acc[0] ? word[0] : word[1];
        wdata1 = word[1];

        pop       = (count_q != '0) && bus.out_ready;
        wr_ptr_p1 = wr_ptr_q + AW'(1);

        wr_ptr_d = wr_ptr_q + AW'(n_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(n_wr) - CW'(pop);

        drop_sum = {1'b0, drop_q} + (MXCNTB + 1)'(n_drop);
        drop_d   = drop_sum[MXCNTB] ? '1 : drop_sum[MXCNTB-1:0];

        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clock) begin
        if (n_wr != 2'd0) begin
            mem_q[wr_ptr_q] <= wdata0;
        end
        if (n_wr == 2'd2) begin
            mem_q[wr_ptr_p1] <= wdata1;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign word_count    = count_q;
    assign drop_count    = drop_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_cclut_clct_packer.sv
// tb_cclut_clct_packer: table-driven single-strobe vectors plus directed
// sequences for fill/overflow, full-with-read, streaming and async reset.
module tb_cclut_clct_packer;
    logic       clk;
    logic       rst;
    logic [2:0] hit_thresh;
    logic [3:0] ghost_sep;
    logic [3:0] word_count;
    logic [15:0] drop_count;
    logic       overflow;

    int total;
    int bad;

    cclut_clct_packer_if bus ();

    cclut_clct_packer dut (
        .clock      (clk),
        .reset      (rst),
        .bus        (bus),
        .hit_thresh (hit_thresh),
        .ghost_sep  (ghost_sep),
        .word_count (word_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] thr;
        logic [3:0] sep;
        logic [2:0] h0;
        logic [3:0] p0;
        logic [7:0] k0;
        logic [3:0] o0;
        logic [4:0] b0;
        logic [2:0] h1;
        logic [3:0] p1;
        logic [7:0] k1;
        logic [3:0] o1;
        logic [4:0] b1;
        logic [1:0] code;  // bit0: CLCT0 expected out, bit1: CLCT1 expected out
    } vec_t;

    vec_t vecs[12];
    logic [23:0] exp_q[$];

    function automatic vec_t mk(input logic [2:0] thr, input logic [3:0] sep,
                                input logic [2:0] h0, input logic [3:0] p0,
                                input logic [7:0] k0, input logic [3:0] o0,
                                input logic [4:0] b0, input logic [2:0] h1,
                                input logic [3:0] p1, input logic [7:0] k1,
                                input logic [3:0] o1, input logic [4:0] b1,
                                input logic [1:0] code);
        vec_t v;
        v.thr = thr; v.sep = sep;
        v.h0 = h0; v.p0 = p0; v.k0 = k0; v.o0 = o0; v.b0 = b0;
        v.h1 = h1; v.p1 = p1; v.k1 = k1; v.o1 = o1; v.b1 = b1;
        v.code = code;
        return v;
    endfunction

    function automatic logic [23:0] pack(input logic [2:0] h, input logic [3:0] p,
                                         input logic [7:0] k, input logic [3:0] o,
                                         input logic [4:0] b);
        return {h, p, k, o, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] h0, input logic [3:0] p0, input logic [7:0] k0,
                         input logic [3:0] o0, input logic [4:0] b0,
                         input logic [2:0] h1, input logic [3:0] p1, input logic [7:0] k1,
                         input logic [3:0] o1, input logic [4:0] b1);
        bus.in_strobe = 1'b1;
        bus.hit0 = h0; bus.pid0 = p0; bus.best_key0 = k0; bus.offs0 = o0; bus.bend0 = b0;
        bus.hit1 = h1; bus.pid1 = p1; bus.best_key1 = k1; bus.offs1 = o1; bus.bend1 = b1;
    endtask

    // Two passing CLCTs with given keys (thr=3, sep=0 assumed).
    task automatic drive2(input logic [7:0] k0, input logic [7:0] k1);
        drive(3'd7, 4'd1, k0, 4'd5, 5'd9, 3'd7, 4'd1, k1, 4'd5, 5'd9);
    endtask

    function automatic logic [23:0] w2(input logic [7:0] k);
        return pack(3'd7, 4'd1, k, 4'd5, 5'd9);
    endfunction

    task automatic pop_chk(input string name, input logic [23:0] exp);
        chk({name, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " data"}, 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [23:0] w[2];
        int cnt;
        cnt = 0;
        if (v.code[0]) begin w[cnt] = pack(v.h0, v.p0, v.k0, v.o0, v.b0); cnt++; end
        if (v.code[1]) begin w[cnt] = pack(v.h1, v.p1, v.k1, v.o1, v.b1); cnt++; end
        @(negedge clk);
        hit_thresh = v.thr;
        ghost_sep  = v.sep;
        drive(v.h0, v.p0, v.k0, v.o0, v.b0, v.h1, v.p1, v.k1, v.o1, v.b1);
        @(negedge clk);
        bus.in_strobe = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d count", n), 32'(word_count), 32'(cnt));
        for (int j = 0; j < cnt; j++) pop_chk($sformatf("v%0d w%0d", n, j), w[j]);
        chk($sformatf("v%0d empty", n), 32'(word_count), 32'd0);
        chk($sformatf("v%0d drop", n), 32'(drop_count), 32'd0);
    endtask

    initial begin
        int idx;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        hit_thresh = 3'd3;
        ghost_sep  = 4'd0;
        bus.in_strobe = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, 4'd0, 8'd0, 4'd0, 5'd0, 3'd0, 4'd0, 8'd0, 4'd0, 5'd0);
        bus.in_strobe = 1'b0;

        //           thr  sep   h0    p0    k0     o0    b0      h1    p1    k1     o1    b1
        vecs[0]  = mk(3'd3, 4'd0, 3'd6, 4'd4, 8'h40, 4'd7, 5'h03, 3'd2, 4'd1, 8'h80, 4'd1, 5'h01, 2'd1);
        vecs[1]  = mk(3'd3, 4'd3, 3'd5, 4'd0, 8'h40, 4'd2, 5'h11, 3'd4, 4'd2, 8'h42, 4'd9, 5'h1f, 2'd1);
        vecs[2]  = mk(3'd3, 4'd0, 3'd5, 4'd0, 8'h40, 4'd2, 5'h11, 3'd4, 4'd2, 8'h42, 4'd9, 5'h1f, 2'd3);
        vecs[3]  = mk(3'd3, 4'd3, 3'd5, 4'd0, 8'h40, 4'd1, 5'h05, 3'd4, 4'd2, 8'h43, 4'd3, 5'h15, 2'd3);
        vecs[4]  = mk(3'd3, 4'd3, 3'd5, 4'd0, 8'h42, 4'd1, 5'h05, 3'd4, 4'd2, 8'h40, 4'd3, 5'h15, 2'd1);
        vecs[5]  = mk(3'd3, 4'd0, 3'd7, 4'd5, 8'h10, 4'hf, 5'h1f, 3'd3, 4'd3, 8'h20, 4'd0, 5'h00, 2'd2);
        vecs[6]  = mk(3'd4, 4'd0, 3'd4, 4'd1, 8'h33, 4'd4, 5'h04, 3'd4, 4'd4, 8'h44, 4'd5, 5'h14, 2'd3);
        vecs[7]  = mk(3'd5, 4'd0, 3'd4, 4'd1, 8'h33, 4'd4, 5'h04, 3'd3, 4'd0, 8'h34, 4'd5, 5'h14, 2'd0);
        vecs[8]  = mk(3'd1, 4'hf, 3'd1, 4'd2, 8'h00, 4'ha, 5'h0a, 3'd1, 4'd3, 8'hff, 4'hb, 5'h1b, 2'd3);
        vecs[9]  = mk(3'd0, 4'd0, 3'd0, 4'd4, 8'h7f, 4'd0, 5'h00, 3'd0, 4'd4, 8'h80, 4'hf, 5'h1f, 2'd3);
        vecs[10] = mk(3'd2, 4'd8, 3'd1, 4'd0, 8'h50, 4'd1, 5'h01, 3'd6, 4'd3, 8'h52, 4'd2, 5'h02, 2'd2);
        vecs[11] = mk(3'd3, 4'd2, 3'd3, 4'd1, 8'ha0, 4'd6, 5'h06, 3'd3, 4'd6, 8'ha1, 4'd6, 5'h06, 2'd1);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset valid", 32'(bus.out_valid), 32'd0);
        chk("reset count", 32'(word_count), 32'd0);
        chk("reset drop", 32'(drop_count), 32'd0);
        chk("reset ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Latency: word must not be visible one cycle after the strobe.
        hit_thresh = 3'd3;
        ghost_sep  = 4'd0;
        @(negedge clk);
        drive(3'd6, 4'd4, 8'h40, 4'd7, 5'h03, 3'd2, 4'd0, 8'h00, 4'd0, 5'h00);
        @(negedge clk);
        bus.in_strobe = 1'b0;
        chk("lat t+1 valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        pop_chk("lat t+2", pack(3'd6, 4'd4, 8'h40, 4'd7, 5'h03));

        // Fill: five double strobes into an 8-deep FIFO, last strobe lost.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive2(8'(16 * i), 8'(16 * i + 8));
        end
        @(negedge clk);
        bus.in_strobe = 1'b0;
        @(negedge clk);
        chk("fill count", 32'(word_count), 32'd8);
        chk("fill drop", 32'(drop_count), 32'd2);
        chk("fill ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            pop_chk($sformatf("fill pop%0d", i), w2(8'(16 * (i / 2) + 8 * (i % 2))));
        end
        chk("fill count5", 32'(word_count), 32'd5);
        chk("fill ovf sticky", 32'(overflow), 32'd1);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("areset valid", 32'(bus.out_valid), 32'd0);
        chk("areset count", 32'(word_count), 32'd0);
        chk("areset drop", 32'(drop_count), 32'd0);
        chk("areset ovf", 32'(overflow), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        drive2(8'h5a, 8'h5b);
        @(negedge clk);
        bus.in_strobe = 1'b0;
        chk("post-reset t+1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("post-reset count", 32'(word_count), 32'd2);
        pop_chk("post-reset w0", w2(8'h5a));
        pop_chk("post-reset w1", w2(8'h5b));

        // Pop plus writes against a nearly full FIFO.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive2(8'(16 * i), 8'(16 * i + 1));
            exp_q.push_back(w2(8'(16 * i)));
            exp_q.push_back(w2(8'(16 * i + 1)));
        end
        @(negedge clk);
        bus.in_strobe = 1'b0;
        @(negedge clk);
        chk("rw count6", 32'(word_count), 32'd6);
        @(negedge clk);
        drive2(8'ha0, 8'ha1);
        @(negedge clk);
        bus.in_strobe = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(w2(8'ha0));
        exp_q.push_back(w2(8'ha1));
        chk("rw2 count", 32'(word_count), 32'd7);
        chk("rw2 drop", 32'(drop_count), 32'd0);
        chk("rw2 ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        drive2(8'hb0, 8'hb1);
        @(negedge clk);
        bus.in_strobe = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(w2(8'hb0));
        chk("rw1 count", 32'(word_count), 32'd7);
        chk("rw1 drop", 32'(drop_count), 32'd1);
        chk("rw1 ovf", 32'(overflow), 32'd1);
        idx = 0;
        while (exp_q.size() != 0) begin
            pop_chk($sformatf("rw drain%0d", idx), exp_q.pop_front());
            idx++;
        end
        chk("rw drained", 32'(word_count), 32'd0);

        // Streaming: one passing CLCT per cycle with continuous reads.
        do_reset();
        bus.out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk($sformatf("stream w%0d", idx), 32'(bus.out_data),
                    32'(pack(3'd5, 4'd0, 8'(idx), 4'(idx), 5'(idx))));
                idx++;
            end
            chk($sformatf("stream cnt c%0d", c), 32'(word_count <= 4'd1), 32'd1);
            if (c < 20) begin
                drive(3'd5, 4'd0, 8'(c), 4'(c), 5'(c), 3'd1, 4'd0, 8'(c), 4'd0, 5'd0);
            end else begin
                bus.in_strobe = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        chk("stream words", 32'(idx), 32'd20);
        chk("stream drop", 32'(drop_count), 32'd0);
        chk("stream ovf", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
